// File: rtl/maze_cmd_pkg.sv
// Shared types and constants for the maze command sequencer.
// The opcode, heading and acknowledge values match the RemoteComm command set.
package maze_cmd_pkg;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_SENT_TMO = 2'b01,
    ERR_RESP_TMO = 2'b10,
    ERR_BAD_RESP = 2'b11
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_SENT,
    ST_WAIT_RESP,
    ST_NEXT,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [3:0]  CMD_CAL  = 4'h0;
  localparam logic [3:0]  CMD_HDG  = 4'h2;
  localparam logic [3:0]  CMD_MOVE = 4'h4;

  localparam logic [11:0] HDG_N = 12'h000;
  localparam logic [11:0] HDG_W = 12'h3FF;
  localparam logic [11:0] HDG_E = 12'hC00;

  localparam logic [7:0]  RESP_ACK = 8'hA5;

endpackage

// File: rtl/seq_timeout.sv
// Saturating phase timer: cleared on clr, otherwise counts up to LIMIT-1 and holds.
// expired is high while the count sits at LIMIT-1.
module seq_timeout #(
  parameter int unsigned LIMIT = 2560000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (count_q != LAST) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/cmd_sequencer.sv
// Script player for the RemoteComm command interface: sends each loaded command,
// waits for cmd_sent then resp_rdy under timeouts, and halts on the first fault.
module cmd_sequencer
  import maze_cmd_pkg::*;
#(
  parameter int unsigned          CMD_W    = 16,
  parameter int unsigned          RESP_W   = 8,
  parameter int unsigned          DEPTH    = 16,
  parameter int unsigned          TMO_CYC  = 2560000,
  parameter logic [RESP_W-1:0]    EXP_RESP = RESP_ACK
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ld_en,
  input  logic [CMD_W-1:0]          ld_data,
  input  logic                      clr,
  input  logic                      start,
  output logic [CMD_W-1:0]          cmd,
  output logic                      send_cmd,
  input  logic                      cmd_sent,
  input  logic                      resp_rdy,
  input  logic [RESP_W-1:0]         resp,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [1:0]                err_code,
  output logic [$clog2(DEPTH)-1:0]  err_idx,
  output logic [$clog2(DEPTH):0]    cnt,
  output logic                      full
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [CMD_W-1:0] mem [DEPTH];

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             send_q, send_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  err_code_e        err_code_q, err_code_d;
  logic [IW-1:0]    err_idx_q, err_idx_d;
  logic             sent_prev_q, rdy_prev_q;
  logic             sent_edge, rdy_edge, tmo_expired, tmo_clr, wr_en;

  assign sent_edge = cmd_sent & ~sent_prev_q;
  assign rdy_edge  = resp_rdy & ~rdy_prev_q;
  assign full      = (cnt_q == CW'(DEPTH));
  assign wr_en     = (state_q == ST_IDLE) && ld_en && !clr && !full;
  // Every state change starts a fresh wait window for the shared timer.
  assign tmo_clr   = (state_d != state_q);

  seq_timeout #(.LIMIT(TMO_CYC)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmo_clr),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    err_idx_d  = err_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          cnt_d = '0;
        end else if (ld_en && !full) begin
          cnt_d = cnt_q + CW'(1);
        end
        // Playback length follows whatever the buffer holds after this cycle's load/clear.
        if (start) begin
          done_d     = 1'b0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          err_idx_d  = '0;
          idx_d      = '0;
          busy_d     = 1'b1;
          state_d    = (cnt_d == '0) ? ST_DONE : ST_SEND;
        end
      end
      ST_SEND: state_d = ST_WAIT_SENT;
      ST_WAIT_SENT: begin
        if (sent_edge) begin
          state_d = ST_WAIT_RESP;
        end else if (tmo_expired) begin
          err_code_d = ERR_SENT_TMO;
          state_d    = ST_ERR;
        end
      end
      ST_WAIT_RESP: begin
        if (rdy_edge) begin
          if (resp == EXP_RESP) begin
            state_d = ST_NEXT;
          end else begin
            err_code_d = ERR_BAD_RESP;
            state_d    = ST_ERR;
          end
        end else if (tmo_expired) begin
          err_code_d = ERR_RESP_TMO;
          state_d    = ST_ERR;
        end
      end
      ST_NEXT: begin
        if ({1'b0, idx_q} == (cnt_q - CW'(1))) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = ST_SEND;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        err_d     = 1'b1;
        busy_d    = 1'b0;
        err_idx_d = idx_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    send_d = (state_d == ST_SEND);
    if (state_d == ST_SEND) begin
      cmd_d = mem[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[cnt_q[IW-1:0]] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      cmd_q       <= '0;
      send_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_idx_q   <= '0;
      sent_prev_q <= 1'b0;
      rdy_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      send_q      <= send_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      err_idx_q   <= err_idx_d;
      sent_prev_q <= cmd_sent;
      rdy_prev_q  <= resp_rdy;
    end
  end

  assign cmd      = cmd_q;
  assign send_cmd = send_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign err_idx  = err_idx_q;
  assign cnt      = cnt_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Scoreboard bench for cmd_sequencer: a RemoteComm responder model acts on each send,
// a script-level reference model predicts sends and final status, a monitor compares.
module tb_cmd_sequencer;
  import maze_cmd_pkg::*;

  localparam int CMD_W  = 16;
  localparam int RESP_W = 8;
  localparam int DEPTH  = 8;
  localparam int TMO    = 100;
  localparam int IW     = $clog2(DEPTH);

  localparam int B_ACK         = 0;
  localparam int B_BAD         = 1;
  localparam int B_NOSENT      = 2;
  localparam int B_NORESP      = 3;
  localparam int B_HOLD        = 4;
  localparam int B_RESP_AT_TMO = 5;
  localparam int B_RESP_LATE   = 6;

  typedef struct {
    bit         isDone;
    logic [1:0] code;
    int         idx;
    int         latency;
  } result_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ld_en = 1'b0;
  logic [CMD_W-1:0]  ld_data = '0;
  logic              clr = 1'b0;
  logic              start = 1'b0;
  logic              cmd_sent = 1'b0;
  logic              resp_rdy = 1'b0;
  logic [RESP_W-1:0] resp = '0;
  logic [CMD_W-1:0]  cmd;
  logic              send_cmd, busy, done, err, full;
  logic [1:0]        err_code;
  logic [IW-1:0]     err_idx;
  logic [IW:0]       cnt;

  logic [CMD_W-1:0] expCmdQ[$];
  result_t          expResQ[$];
  logic [CMD_W-1:0] script[$];
  int               beh[DEPTH];

  int  nChecks = 0;
  int  nFail = 0;
  int  cycle = 0;
  int  lastSendCycle = -1000;
  int  sendIdx = 0;
  int  respBeh, d1, d2;
  bit  respBusy = 1'b0;
  bit  prevFlag = 1'b0;
  result_t monRes;

  cmd_sequencer #(
    .CMD_W(CMD_W), .RESP_W(RESP_W), .DEPTH(DEPTH), .TMO_CYC(TMO), .EXP_RESP(RESP_ACK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_data(ld_data), .clr(clr), .start(start),
    .cmd(cmd), .send_cmd(send_cmd), .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .err_idx(err_idx),
    .cnt(cnt), .full(full)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic driveResp(input logic [RESP_W-1:0] value);
    resp     = value;
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
    resp     = RESP_W'($urandom);
  endtask

  // RemoteComm model: reacts to each send_cmd according to the per-entry behaviour table
  initial begin : remoteComm
    forever begin
      @(negedge clk);
      if (!busy) sendIdx = 0;
      if (rst_n && send_cmd) begin
        respBeh = (sendIdx < DEPTH) ? beh[sendIdx] : B_ACK;
        sendIdx++;
        if (!cmd_sent && respBeh != B_NOSENT) begin
          respBusy = 1'b1;
          d1 = $urandom_range(1, 4);
          d2 = $urandom_range(1, 4);
          repeat (d1) @(negedge clk);
          cmd_sent = 1'b1;
          if (respBeh == B_HOLD) begin
            repeat (d2) @(negedge clk);
            driveResp(RESP_ACK);
            repeat (TMO + 20) @(negedge clk);
            cmd_sent = 1'b0;
          end else begin
            @(negedge clk);
            cmd_sent = 1'b0;
            case (respBeh)
              B_ACK: begin
                repeat (d2 - 1) @(negedge clk);
                driveResp(RESP_ACK);
              end
              B_BAD: begin
                repeat (d2 - 1) @(negedge clk);
                driveResp(8'h5A);
              end
              B_RESP_AT_TMO: begin
                repeat (TMO - 1) @(negedge clk);
                driveResp(RESP_ACK);
              end
              B_RESP_LATE: begin
                repeat (TMO) @(negedge clk);
                driveResp(RESP_ACK);
              end
              default: ;
            endcase
          end
          respBusy = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every send and on every rising done/err
  initial begin : monitor
    forever begin
      @(negedge clk);
      cycle++;
      if (!rst_n) begin
        prevFlag = 1'b0;
      end else begin
        if (send_cmd) begin
          checkOutput("send gap ok", 32'(cycle - lastSendCycle >= 3), 32'd1);
          if (expCmdQ.size() == 0) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL unexpected send_cmd: got cmd 0x%0h, expected no send", cmd);
          end else begin
            checkOutput("cmd", 32'(cmd), 32'(expCmdQ.pop_front()));
          end
          lastSendCycle = cycle;
        end
        if ((done || err) && !prevFlag) begin
          if (expResQ.size() == 0) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL unexpected completion: got done=%0b err=%0b, expected none", done, err);
          end else begin
            monRes = expResQ.pop_front();
            checkOutput("done", 32'(done), 32'(monRes.isDone));
            checkOutput("err", 32'(err), 32'(!monRes.isDone));
            checkOutput("err_code", 32'(err_code), 32'(monRes.code));
            if (!monRes.isDone) checkOutput("err_idx", 32'(err_idx), 32'(monRes.idx));
            checkOutput("busy at end", 32'(busy), 32'd0);
            if (monRes.latency > 0)
              checkOutput("sent timeout latency", 32'(cycle - lastSendCycle), 32'(monRes.latency));
          end
        end
        prevFlag = done || err;
      end
    end
  end

  task automatic loadEntry(input logic [CMD_W-1:0] data);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
    if (script.size() < DEPTH) script.push_back(data);
  endtask

  task automatic clearScript();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    script.delete();
  endtask

  task automatic setAllBeh(input int b);
    for (int i = 0; i < DEPTH; i++) beh[i] = b;
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Reference model: an entry fails by its own behaviour, or with a sent timeout
  // when the previous entry left cmd_sent stuck high.
  task automatic runScript();
    bit      held = 1'b0;
    bit      failed = 1'b0;
    int      k;
    int      budget;
    result_t r;
    for (int i = 0; i < script.size(); i++) begin
      expCmdQ.push_back(script[i]);
      r.isDone  = 1'b0;
      r.idx     = i;
      r.latency = 0;
      r.code    = ERR_NONE;
      if (held) begin
        r.code = ERR_SENT_TMO; r.latency = TMO + 2; failed = 1'b1;
      end else if (beh[i] == B_BAD) begin
        r.code = ERR_BAD_RESP; failed = 1'b1;
      end else if (beh[i] == B_NOSENT) begin
        r.code = ERR_SENT_TMO; r.latency = TMO + 2; failed = 1'b1;
      end else if (beh[i] == B_NORESP || beh[i] == B_RESP_LATE) begin
        r.code = ERR_RESP_TMO; failed = 1'b1;
      end
      held = (beh[i] == B_HOLD);
      if (failed) begin
        expResQ.push_back(r);
        break;
      end
    end
    if (!failed) begin
      r.isDone = 1'b1; r.code = ERR_NONE; r.idx = 0; r.latency = 0;
      expResQ.push_back(r);
    end
    budget = (script.size() + 1) * (3 * TMO + 20);
    applyStimulus();
    if (script.size() == 0) begin
      checkOutput("empty start done pending", 32'(done), 32'd0);
      @(negedge clk);
      checkOutput("empty start done next cycle", 32'(done), 32'd1);
    end
    k = 0;
    while (!(done || err) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!(done || err)) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL playback completion: got no done/err after %0d cycles, expected done or err", budget);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      expCmdQ.delete();
      expResQ.delete();
      script.delete();
    end
    k = 0;
    while (respBusy && k < 4 * TMO) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    checkOutput("cmd scoreboard drained", 32'(expCmdQ.size()), 32'd0);
    checkOutput("result scoreboard drained", 32'(expResQ.size()), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    setAllBeh(B_ACK);
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    checkOutput("reset send_cmd", 32'(send_cmd), 32'd0);
    checkOutput("reset cnt", 32'(cnt), 32'd0);
    checkOutput("reset full", 32'(full), 32'd0);
    checkOutput("reset cmd", 32'(cmd), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    loadEntry({CMD_CAL, HDG_N});
    loadEntry({CMD_HDG, HDG_N});
    loadEntry({CMD_MOVE, 12'h002});
    checkOutput("cnt after three loads", 32'(cnt), 32'd3);
    runScript();

    beh[1] = B_NOSENT;
    runScript();
    setAllBeh(B_ACK);
    beh[0] = B_BAD;
    runScript();
    setAllBeh(B_ACK);
    beh[2] = B_RESP_LATE;
    runScript();
    setAllBeh(B_ACK);
    beh[1] = B_RESP_AT_TMO;
    runScript();
    setAllBeh(B_ACK);
    beh[0] = B_HOLD;
    runScript();

    setAllBeh(B_ACK);
    clearScript();
    for (int i = 0; i < DEPTH + 2; i++) loadEntry(CMD_W'($urandom));
    checkOutput("cnt when full", 32'(cnt), 32'(DEPTH));
    checkOutput("full flag", 32'(full), 32'd1);
    runScript();
    clearScript();
    checkOutput("cnt after clr", 32'(cnt), 32'd0);
    runScript();

    for (int t = 0; t < 6; t++) begin
      clearScript();
      setAllBeh(B_ACK);
      for (int i = 0; i < int'($urandom_range(1, DEPTH)); i++) begin
        loadEntry({CMD_MOVE, 12'($urandom)});
        if ($urandom_range(0, 3) == 0) beh[i] = int'($urandom_range(B_BAD, B_NORESP));
      end
      runScript();
    end

    clearScript();
    setAllBeh(B_ACK);
    beh[0] = B_NORESP;
    loadEntry({CMD_HDG, HDG_W});
    loadEntry({CMD_HDG, HDG_E});
    expCmdQ.push_back(script[0]);
    applyStimulus();
    repeat (10) @(negedge clk);
    checkOutput("busy during playback", 32'(busy), 32'd1);
    ld_en = 1'b1;
    ld_data = 16'hFFFF;
    clr = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    checkOutput("ld_en/clr ignored while busy", 32'(cnt), 32'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort send_cmd", 32'(send_cmd), 32'd0);
    checkOutput("abort cnt", 32'(cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    script.delete();
    runScript();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/cmd_sequencer.md
Name: cmd_sequencer

Overview:
Synthesizable, parametrised command script player that drives the RemoteComm-side command interface (cmd/send_cmd/cmd_sent/resp_rdy/resp). It replaces hand-sequenced send/wait/check steps with a loadable script buffer: it sends each command in order, waits for cmd_sent and then resp_rdy under per-phase timeouts, and checks the response byte. It halts with an error code and the failing index on the first fault. It is used in bench harnesses and on-board self-test alongside RemoteComm.

Parameters:
CMD_W, 16, command word width
RESP_W, 8, response byte width
DEPTH, 16, script entries (power of 2, >=2)
TMO_CYC, 2560000, timeout in clocks for each wait phase
EXP_RESP, 8'hA5, required response value

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ld_en  in  1  write ld_data to the script buffer (honoured only in IDLE)
ld_data  in  CMD_W  script entry
clr  in  1  empty the script buffer (honoured only in IDLE)
start  in  1  begin playback from entry 0
cmd  out  CMD_W  command to RemoteComm
send_cmd  out  1  one-cycle send strobe
cmd_sent  in  1  RemoteComm has finished transmitting
resp_rdy  in  1  response byte valid
resp  in  RESP_W  response byte
busy  out  1  high from start until DONE/ERR
done  out  1  sticky; all entries passed
err  out  1  sticky; playback aborted
err_code  out  2  00 none, 01 sent timeout, 10 resp timeout, 11 bad resp
err_idx  out  $clog2(DEPTH)  index of the failing entry
cnt  out  $clog2(DEPTH)+1  number of entries loaded
full  out  1  cnt==DEPTH

Behaviour:
- Reset: all outputs 0, cnt=0, state IDLE, buffer contents don't-care.
- IDLE:
  - ld_en with !full: mem[cnt] <= ld_data, cnt++. ld_en while full: ignored, no error.
  - clr: cnt <= 0. clr wins over a simultaneous ld_en.
  - start: clears done/err/err_code/err_idx, idx <= 0, busy <= 1.
    - cnt==0: go to DONE (done=1 the following cycle).
    - otherwise: go to SEND.
  - ld_en, clr and start are ignored in every state other than IDLE.
- SEND (1 cycle): cmd <= mem[idx], send_cmd=1, timer <= 0, go to WAIT_SENT. cmd holds its value until the next SEND.
- WAIT_SENT:
  - Exits on a rising edge of cmd_sent, tracked by a registered previous value. A cmd_sent already high on entry does not count.
  - On the edge: timer <= 0, go to WAIT_RESP.
  - Timer reaches TMO_CYC-1 with no edge: err_code=01, go to ERR.
- WAIT_RESP:
  - Exits on a rising edge of resp_rdy; resp is sampled in the same cycle.
  - resp==EXP_RESP: go to NEXT.
  - resp mismatch: err_code=11, go to ERR.
  - Timeout: err_code=10, go to ERR.
  - An edge and a timeout in the same cycle: the edge wins.
- NEXT (1 cycle):
  - idx==cnt-1: go to DONE.
  - otherwise: idx++, go to SEND.
- DONE / ERR:
  - Set done or err respectively (sticky); busy <= 0; err_idx <= idx on error; return to IDLE next cycle.
  - Flags hold until the next start or reset.
- Timer: counter wide enough for TMO_CYC; saturates; cleared on each phase entry.
- Gap: 2 cycles minimum between successive send_cmd pulses (NEXT, SEND).
- Reset mid-playback: immediate abort to reset values, script content lost (cnt=0).

Decomposition:
- Package maze_cmd_pkg:
  - err_code enum (ERR_NONE, ERR_SENT_TMO, ERR_RESP_TMO, ERR_BAD_RESP)
  - state enum
  - opcode constants: CMD_CAL=4'h0, CMD_HDG=4'h2, CMD_MOVE=4'h4
  - heading constants: HDG_N=12'h000, HDG_W=12'h3FF, HDG_E=12'hC00
  - RESP_ACK=8'hA5
- Sub-module seq_timeout: parametrised saturating counter with clr and expired outputs, instantiated once and shared by both wait phases.
- The script buffer is inline (register array, write pointer = cnt).

Test Plan:
- Load 0x0000, 0x2000, 0x4002; start; a RemoteComm model acks each with cmd_sent then resp=0xA5 → three send_cmd pulses carrying 0x0000, 0x2000, 0x4002 in order; done=1, err=0.
- TMO_CYC=100, model never raises cmd_sent on entry 1 → err=1, err_code=01, err_idx=1 on cycle 100 of WAIT_SENT; no further send_cmd.
- Model returns resp=0x5A for entry 0 → err_code=11, err_idx=0, done=0.
- Load DEPTH+2 entries → cnt=DEPTH, full=1; playback issues exactly DEPTH sends; clr then start → done=1 with no sends.
- cmd_sent held high across two commands (no edge) → WAIT_SENT times out with err_code=01; same-cycle resp_rdy edge and timeout → treated as a response.
- Assert rst_n low during WAIT_RESP → busy=0, send_cmd=0, cnt=0 immediately; start after reset → done next cycle.
